// File: rtl/lfclk_rtc_timer.sv
// lfclk_rtc_timer
//   RTC timer driven by the 32.768 kHz divided clock, which is sampled as
//   data in the clk8388 domain. Rising edges of the low-frequency clock are
//   prescaled into ticks, and each tick advances a free-running counter.
//   Also provides a compare register, a sticky match interrupt, a sticky
//   wrap flag and a two-state register-write handshake.
//
// Ports
//   clk8388    in   system clock
//   rst_n      in   asynchronous active-low reset
//   lf_clk_in  in   low-frequency clock, treated as asynchronous data
//   cfg_en     in   counter enable
//   cfg_presc  in   tick every cfg_presc+1 lf rising edges
//   wr_valid   in   write request
//   wr_sel     in   0 counter, 1 compare, 2 clear flags, 3 reserved
//   wr_data    in   write data
//   wr_ready   out  write request accepted when high
//   rtc_cnt    out  counter value
//   rtc_cmp    out  compare value
//   tick_o     out  one-cycle pulse, aligned with the new rtc_cnt
//   irq_o      out  sticky compare-match flag
//   ovf_o      out  sticky counter-wrap flag
module lfclk_rtc_timer #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned PRESC_W = 4
) (
    input  logic               clk8388,
    input  logic               rst_n,
    input  logic               lf_clk_in,
    input  logic               cfg_en,
    input  logic [PRESC_W-1:0] cfg_presc,
    input  logic               wr_valid,
    input  logic [1:0]         wr_sel,
    input  logic [CNT_W-1:0]   wr_data,
    output logic               wr_ready,
    output logic [CNT_W-1:0]   rtc_cnt,
    output logic [CNT_W-1:0]   rtc_cmp,
    output logic               tick_o,
    output logic               irq_o,
    output logic               ovf_o
);

    typedef enum logic [0:0] {StIdle, StAck} wr_state_e;

    logic               r_s1, r_s2, r_s3;
    logic [PRESC_W-1:0] r_presc;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_cmp;
    logic               r_tick;
    logic               r_irq;
    logic               r_ovf;
    wr_state_e          r_state;
    logic [1:0]         r_wr_sel;
    logic [CNT_W-1:0]   r_wr_data;

    wr_state_e          w_state_d;
    logic               w_accept;
    logic               w_lf_rise;
    logic               w_tick;
    logic               w_apply;
    logic               w_wr_cnt;
    logic               w_wr_cmp;
    logic               w_wr_clr;
    logic               w_inc;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_irq_set;
    logic               w_ovf_set;

    // Three-stage sampler: s1/s2 resynchronise, s3 delays for edge detection.
    always_ff @(posedge clk8388 or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= lf_clk_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_lf_rise = r_s2 & ~r_s3;
    assign w_tick    = cfg_en & w_lf_rise & (r_presc == cfg_presc);

    // Write handshake: accept in StIdle, apply the latched write in StAck.
    always_comb begin
        w_state_d = r_state;
        wr_ready  = 1'b0;
        w_accept  = 1'b0;
        w_apply   = 1'b0;
        unique case (r_state)
            StIdle: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    w_accept  = 1'b1;
                    w_state_d = StAck;
                end
            end
            StAck: begin
                w_apply   = 1'b1;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk8388 or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_wr_sel  <= 2'd0;
            r_wr_data <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_wr_sel  <= wr_sel;
                r_wr_data <= wr_data;
            end
        end
    end

    assign w_wr_cnt = w_apply & (r_wr_sel == 2'd0);
    assign w_wr_cmp = w_apply & (r_wr_sel == 2'd1);
    assign w_wr_clr = w_apply & (r_wr_sel == 2'd2);

    // A counter write overrides a coincident tick; the tick pulse still shows.
    assign w_inc     = w_tick & ~w_wr_cnt;
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_irq_set = w_inc & (w_cnt_inc == r_cmp);
    assign w_ovf_set = w_inc & (r_cnt == '1);

    always_ff @(posedge clk8388 or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (!cfg_en || w_wr_cnt) begin
            r_presc <= '0;
        end else if (w_lf_rise) begin
            // >= so an out-of-range count after a live cfg_presc change restarts.
            if (r_presc >= cfg_presc) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PRESC_W'(1);
            end
        end
    end

    always_ff @(posedge clk8388 or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_cmp  <= '1;
            r_tick <= 1'b0;
            r_irq  <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_tick <= w_tick;
            if (w_wr_cnt) begin
                r_cnt <= r_wr_data;
            end else if (w_inc) begin
                r_cnt <= w_cnt_inc;
            end
            if (w_wr_cmp) begin
                r_cmp <= r_wr_data;
            end
            // Set has priority over a coincident clear.
            if (w_irq_set) begin
                r_irq <= 1'b1;
            end else if (w_wr_clr && r_wr_data[0]) begin
                r_irq <= 1'b0;
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_wr_clr && r_wr_data[1]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign rtc_cnt = r_cnt;
    assign rtc_cmp = r_cmp;
    assign tick_o  = r_tick;
    assign irq_o   = r_irq;
    assign ovf_o   = r_ovf;

endmodule

// File: tb/tb_lfclk_rtc_timer.sv
// Directed testbench for lfclk_rtc_timer: a table of run/write vectors with
// hand-computed results, followed by hand-written multi-cycle sequences for
// tick latency, write handshake timing, coincident events and reset.
module tb_lfclk_rtc_timer;

    logic        clk8388;
    logic        rst_n;
    logic        lf_clk_in;
    logic        cfg_en;
    logic [3:0]  cfg_presc;
    logic        wr_valid;
    logic [1:0]  wr_sel;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic [31:0] rtc_cnt;
    logic [31:0] rtc_cmp;
    logic        tick_o;
    logic        irq_o;
    logic        ovf_o;

    lfclk_rtc_timer #(
        .CNT_W   (32),
        .PRESC_W (4)
    ) dut (
        .clk8388   (clk8388),
        .rst_n     (rst_n),
        .lf_clk_in (lf_clk_in),
        .cfg_en    (cfg_en),
        .cfg_presc (cfg_presc),
        .wr_valid  (wr_valid),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rtc_cnt   (rtc_cnt),
        .rtc_cmp   (rtc_cmp),
        .tick_o    (tick_o),
        .irq_o     (irq_o),
        .ovf_o     (ovf_o)
    );

    initial clk8388 = 1'b0;
    always #5 clk8388 = ~clk8388;

    int n_vec  = 0;
    int n_miss = 0;
    int tick_cnt = 0;

    always @(negedge clk8388) begin
        if (tick_o === 1'b1) tick_cnt++;
    end

    typedef struct {
        int          op;      // 0 = run lf edges, 1 = register write
        logic        en;
        logic [3:0]  presc;
        logic [1:0]  sel;
        logic [31:0] data;
        int          n;
        logic [31:0] e_cnt;
        logic [31:0] e_cmp;
        int          e_ticks;
        logic        e_irq;
        logic        e_ovf;
    } vec_t;

    localparam int NV = 17;
    vec_t vec [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk8388);
        #1;
    endtask

    task automatic run_edges(input int n);
        for (int i = 0; i < n; i++) begin
            lf_clk_in = 1'b1;
            step(128);
            lf_clk_in = 1'b0;
            step(128);
        end
        if (n == 0) step(20);
    endtask

    // Full handshake: wait for ready, present one beat, let ACK apply it.
    task automatic do_write(input logic [1:0] sel, input logic [31:0] data);
        int k;
        k = 0;
        while (wr_ready !== 1'b1 && k < 10) begin
            step(1);
            k++;
        end
        if (k == 10) check("wr_ready_timeout", {63'd0, wr_ready}, 64'd1);
        wr_valid = 1'b1;
        wr_sel   = sel;
        wr_data  = data;
        step(1);
        wr_valid = 1'b0;
        step(1);
    endtask

    initial begin
        rst_n     = 1'b0;
        lf_clk_in = 1'b0;
        cfg_en    = 1'b0;
        cfg_presc = 4'd0;
        wr_valid  = 1'b0;
        wr_sel    = 2'd0;
        wr_data   = 32'd0;

        //            op en presc sel data          n   cnt           cmp           tk irq ovf
        vec[0]  = '{0, 1'b0, 4'd0, 2'd0, 32'd0,        3,  32'd0,        32'hFFFFFFFF, 0,  1'b0, 1'b0};
        vec[1]  = '{0, 1'b1, 4'd0, 2'd0, 32'd0,        10, 32'd10,       32'hFFFFFFFF, 10, 1'b0, 1'b0};
        vec[2]  = '{1, 1'b1, 4'd0, 2'd0, 32'd0,        0,  32'd0,        32'hFFFFFFFF, 0,  1'b0, 1'b0};
        vec[3]  = '{0, 1'b1, 4'd3, 2'd0, 32'd0,        12, 32'd3,        32'hFFFFFFFF, 3,  1'b0, 1'b0};
        vec[4]  = '{0, 1'b1, 4'd3, 2'd0, 32'd0,        2,  32'd3,        32'hFFFFFFFF, 0,  1'b0, 1'b0};
        vec[5]  = '{0, 1'b0, 4'd3, 2'd0, 32'd0,        0,  32'd3,        32'hFFFFFFFF, 0,  1'b0, 1'b0};
        vec[6]  = '{0, 1'b1, 4'd3, 2'd0, 32'd0,        3,  32'd3,        32'hFFFFFFFF, 0,  1'b0, 1'b0};
        vec[7]  = '{0, 1'b1, 4'd3, 2'd0, 32'd0,        1,  32'd4,        32'hFFFFFFFF, 1,  1'b0, 1'b0};
        vec[8]  = '{1, 1'b1, 4'd3, 2'd0, 32'd0,        0,  32'd0,        32'hFFFFFFFF, 0,  1'b0, 1'b0};
        vec[9]  = '{1, 1'b1, 4'd3, 2'd1, 32'd5,        0,  32'd0,        32'd5,        0,  1'b0, 1'b0};
        vec[10] = '{0, 1'b1, 4'd0, 2'd0, 32'd0,        4,  32'd4,        32'd5,        4,  1'b0, 1'b0};
        vec[11] = '{0, 1'b1, 4'd0, 2'd0, 32'd0,        1,  32'd5,        32'd5,        1,  1'b1, 1'b0};
        vec[12] = '{1, 1'b1, 4'd0, 2'd2, 32'd1,        0,  32'd5,        32'd5,        0,  1'b0, 1'b0};
        vec[13] = '{1, 1'b1, 4'd0, 2'd0, 32'hFFFFFFFE, 0,  32'hFFFFFFFE, 32'd5,        0,  1'b0, 1'b0};
        vec[14] = '{0, 1'b1, 4'd0, 2'd0, 32'd0,        2,  32'd0,        32'd5,        2,  1'b0, 1'b1};
        vec[15] = '{1, 1'b1, 4'd0, 2'd3, 32'd3,        0,  32'd0,        32'd5,        0,  1'b0, 1'b1};
        vec[16] = '{1, 1'b1, 4'd0, 2'd2, 32'd2,        0,  32'd0,        32'd5,        0,  1'b0, 1'b0};

        step(3);
        rst_n = 1'b1;
        step(2);
        check("rst_cnt",   {32'd0, rtc_cnt}, 64'd0);
        check("rst_cmp",   {32'd0, rtc_cmp}, 64'hFFFFFFFF);
        check("rst_tick",  {63'd0, tick_o},   64'd0);
        check("rst_irq",   {63'd0, irq_o},    64'd0);
        check("rst_ovf",   {63'd0, ovf_o},    64'd0);
        check("rst_ready", {63'd0, wr_ready}, 64'd1);

        for (int i = 0; i < NV; i++) begin
            int t0;
            t0 = tick_cnt;
            if (vec[i].op == 0) begin
                // Presc only changes with the counter disabled.
                if (vec[i].presc != cfg_presc) begin
                    cfg_en = 1'b0;
                    step(1);
                    cfg_presc = vec[i].presc;
                end
                cfg_en = vec[i].en;
                step(1);
                run_edges(vec[i].n);
            end else begin
                do_write(vec[i].sel, vec[i].data);
                step(1);
            end
            check($sformatf("v%0d_cnt", i),   {32'd0, rtc_cnt}, {32'd0, vec[i].e_cnt});
            check($sformatf("v%0d_cmp", i),   {32'd0, rtc_cmp}, {32'd0, vec[i].e_cmp});
            check($sformatf("v%0d_ticks", i), 64'(tick_cnt - t0), 64'(vec[i].e_ticks));
            check($sformatf("v%0d_irq", i),   {63'd0, irq_o}, {63'd0, vec[i].e_irq});
            check($sformatf("v%0d_ovf", i),   {63'd0, ovf_o}, {63'd0, vec[i].e_ovf});
        end

        // Tick latency: input driven after edge K, tick_o visible after K+3 only.
        lf_clk_in = 1'b1;
        step(2);
        check("lat_k2_tick", {63'd0, tick_o}, 64'd0);
        step(1);
        check("lat_k3_tick", {63'd0, tick_o}, 64'd1);
        check("lat_k3_cnt",  {32'd0, rtc_cnt}, 64'd1);
        step(1);
        check("lat_k4_tick", {63'd0, tick_o}, 64'd0);
        step(60);
        check("lat_held_cnt", {32'd0, rtc_cnt}, 64'd1);
        lf_clk_in = 1'b0;
        step(20);

        // wr_ready low for exactly one cycle around an accepted write.
        wr_valid = 1'b1;
        wr_sel   = 2'd0;
        wr_data  = 32'd4;
        step(1);
        wr_valid = 1'b0;
        check("hs_ack_ready", {63'd0, wr_ready}, 64'd0);
        step(1);
        check("hs_idle_ready", {63'd0, wr_ready}, 64'd1);
        check("hs_cnt", {32'd0, rtc_cnt}, 64'd4);

        // Flag clear applied in the same cycle as a match: set wins.
        lf_clk_in = 1'b1;
        step(1);
        wr_valid = 1'b1;
        wr_sel   = 2'd2;
        wr_data  = 32'd1;
        step(1);
        wr_valid = 1'b0;
        step(1);
        check("coin_clr_irq", {63'd0, irq_o}, 64'd1);
        check("coin_clr_cnt", {32'd0, rtc_cnt}, 64'd5);
        lf_clk_in = 1'b0;
        step(20);

        // Counter write applied in the same cycle as a tick: write wins.
        lf_clk_in = 1'b1;
        step(1);
        wr_valid = 1'b1;
        wr_sel   = 2'd0;
        wr_data  = 32'h1234;
        step(1);
        wr_valid = 1'b0;
        step(1);
        check("coin_wr_cnt",  {32'd0, rtc_cnt}, 64'h1234);
        check("coin_wr_tick", {63'd0, tick_o},  64'd1);
        lf_clk_in = 1'b0;
        step(20);
        check("coin_wr_hold", {32'd0, rtc_cnt}, 64'h1234);

        // Reset during ACK of a compare write drops the write.
        wr_valid = 1'b1;
        wr_sel   = 2'd1;
        wr_data  = 32'd7;
        step(1);
        wr_valid = 1'b0;
        check("rw_in_ack", {63'd0, wr_ready}, 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rw_rst_cmp", {32'd0, rtc_cmp}, 64'hFFFFFFFF);
        step(2);
        rst_n = 1'b1;
        step(3);
        check("rw_post_cmp",   {32'd0, rtc_cmp}, 64'hFFFFFFFF);
        check("rw_post_cnt",   {32'd0, rtc_cnt}, 64'd0);
        check("rw_post_irq",   {63'd0, irq_o},    64'd0);
        check("rw_post_ready", {63'd0, wr_ready}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
